// File: rtl/cdb_broadcast_pkg.sv
// Shared types for the complete-stage CDB arbiter: result packet, CDB tag
// bundle, per-FU ready bundle and the FU bit ordering.
package cdb_broadcast_pkg;

  localparam int PRW  = 6;
  localparam int XLEN = 32;
  localparam int ROBW = 5;
  localparam int NFU  = 8;
  localparam int CDBW = 3;
  localparam int PTRW = $clog2(NFU);

  typedef enum logic [2:0] {
    FU_ALU_1  = 3'd0,
    FU_ALU_2  = 3'd1,
    FU_ALU_3  = 3'd2,
    FU_MULT_1 = 3'd3,
    FU_MULT_2 = 3'd4,
    FU_LS_1   = 3'd5,
    FU_LS_2   = 3'd6,
    FU_BRANCH = 3'd7
  } fu_idx_e;

  typedef struct packed {
    logic [PRW-1:0]  dest_pr;
    logic [XLEN-1:0] value;
    logic [ROBW-1:0] rob_idx;
  } FU_RESULT_PACKET;

  typedef struct packed {
    logic [PRW-1:0] t2;
    logic [PRW-1:0] t1;
    logic [PRW-1:0] t0;
  } CDB_T_PACKET;

  // Last field is bit 0 so the struct lines up with the fu_idx_e ordering.
  typedef struct packed {
    logic branch;
    logic storeload_2;
    logic storeload_1;
    logic mult_2;
    logic mult_1;
    logic alu_3;
    logic alu_2;
    logic alu_1;
  } FU_STATE_PACKET;

  localparam int RESW = $bits(FU_RESULT_PACKET);

  function automatic FU_RESULT_PACKET result_mux(
    input FU_RESULT_PACKET [NFU-1:0] slots,
    input logic [NFU-1:0]            onehot
  );
    logic [RESW-1:0] acc;
    acc = '0;
    for (int k = 0; k < NFU; k++) begin
      acc = acc | (slots[k] & {RESW{onehot[k]}});
    end
    return FU_RESULT_PACKET'(acc);
  endfunction

endpackage

// File: rtl/cdb_broadcast_if.sv
// FU-side and CDB-side bundle of the complete-stage arbiter.
interface cdb_broadcast_if;
  import cdb_broadcast_pkg::*;

  logic [NFU-1:0]               fu_done;
  FU_RESULT_PACKET [NFU-1:0]    fu_result;
  logic [NFU-1:0]               fu_busy;
  CDB_T_PACKET                  cdb_t;
  FU_RESULT_PACKET [CDBW-1:0]   cdb_pckt;
  logic [CDBW-1:0]              cdb_valid;
  FU_STATE_PACKET               fu_ready;

  modport master (
    output fu_done, fu_result, fu_busy,
    input  cdb_t, cdb_pckt, cdb_valid, fu_ready
  );

  modport slave (
    input  fu_done, fu_result, fu_busy,
    output cdb_t, cdb_pckt, cdb_valid, fu_ready
  );
endinterface

// File: rtl/cdb_broadcast_chk.sv
// Protocol checks for the complete-stage arbiter.
module cdb_broadcast_chk
  import cdb_broadcast_pkg::*;
(
  input logic           clock,
  input logic           reset,
  input logic           squash,
  input logic [NFU-1:0] fu_done,
  input logic [NFU-1:0] slot_valid,
  input logic [NFU-1:0] grant
);

  // A unit may only finish into an empty slot or one draining this edge.
  overwrite_a: assert property (@(posedge clock) disable iff (reset)
    !squash |-> ((fu_done & slot_valid & ~grant) == {NFU{1'b0}}))
    else $error("cdb_broadcast: result overwrote pending slot(s) %b",
                fu_done & slot_valid & ~grant);

endmodule

// File: rtl/cdb_broadcast_rr_sel8.sv
// Rotating-priority selector: up to CDBW one-hot grants starting at ptr,
// first grant on the highest lane, plus the pointer past the last grant.
module rr_sel8
  import cdb_broadcast_pkg::*;
(
  input  logic [NFU-1:0]             req,
  input  logic [PTRW-1:0]            ptr,
  output logic [CDBW-1:0][NFU-1:0]   gnt,
  output logic [PTRW-1:0]            next_ptr
);

  logic [PTRW-1:0] idx;
  logic [1:0]      cnt;
  logic [1:0]      lane;

  // Walk the slots from ptr, filling lanes top-down.
  always_comb begin
    gnt      = '0;
    next_ptr = ptr;
    idx      = ptr;
    cnt      = 2'd0;
    lane     = 2'd0;
    for (int i = 0; i < NFU; i++) begin
      idx = ptr + PTRW'(i);
      if (req[idx] && (cnt < 2'(CDBW))) begin
        lane           = 2'(CDBW - 1) - cnt;
        gnt[lane][idx] = 1'b1;
        next_ptr       = idx + {{(PTRW-1){1'b0}}, 1'b1};
        cnt            = cnt + 2'd1;
      end else begin
        lane = lane;
      end
    end
  end

endmodule

// File: rtl/cdb_broadcast.sv
// Complete-stage arbiter: one holding slot per FU, up to three results per
// cycle onto the CDB, and per-FU ready back to issue select.
module cdb_broadcast
  import cdb_broadcast_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  input  logic           squash,
  cdb_broadcast_if.slave bus
);

  logic [NFU-1:0]             slot_valid;
  FU_RESULT_PACKET [NFU-1:0]  slot;
  logic [PTRW-1:0]            ptr;
  logic [PTRW-1:0]            next_ptr;
  logic [CDBW-1:0][NFU-1:0]   gnt;
  logic [NFU-1:0]             grant;
  FU_RESULT_PACKET [CDBW-1:0] cdb_pckt_q;
  logic [CDBW-1:0]            cdb_valid_q;

  rr_sel8 u_sel (
    .req      (slot_valid),
    .ptr      (ptr),
    .gnt      (gnt),
    .next_ptr (next_ptr)
  );

  // Union of the per-lane grants.
  always_comb begin
    grant = '0;
    for (int l = 0; l < CDBW; l++) begin
      grant = grant | gnt[l];
    end
  end

  // Slot capture/drain, CDB registers and rotate pointer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_valid  <= '0;
      slot        <= '0;
      ptr         <= '0;
      cdb_pckt_q  <= '0;
      cdb_valid_q <= '0;
    end else if (squash) begin
      slot_valid  <= '0;
      cdb_pckt_q  <= '0;
      cdb_valid_q <= '0;
    end else begin
      for (int k = 0; k < NFU; k++) begin
        // A same-edge finish refills a draining slot with no bubble.
        if (bus.fu_done[k]) begin
          slot_valid[k] <= 1'b1;
          slot[k]       <= bus.fu_result[k];
        end else if (grant[k]) begin
          slot_valid[k] <= 1'b0;
        end
      end
      for (int l = 0; l < CDBW; l++) begin
        cdb_valid_q[l] <= |gnt[l];
        cdb_pckt_q[l]  <= result_mux(slot, gnt[l]);
      end
      ptr <= next_ptr;
    end
  end

  // Idle lanes hold an all-zero packet, so their tag is the zero register.
  assign bus.cdb_pckt  = cdb_pckt_q;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_t     = '{t2: cdb_pckt_q[2].dest_pr,
                           t1: cdb_pckt_q[1].dest_pr,
                           t0: cdb_pckt_q[0].dest_pr};

  assign bus.fu_ready  = FU_STATE_PACKET'((~slot_valid | grant) & ~bus.fu_busy);

  cdb_broadcast_chk u_chk (
    .clock      (clock),
    .reset      (reset),
    .squash     (squash),
    .fu_done    (bus.fu_done),
    .slot_valid (slot_valid),
    .grant      (grant)
  );

endmodule

// File: tb/tb_cdb_broadcast.sv
// Bench for cdb_broadcast: directed vectors, a slot/queue reference model
// compared every cycle, and hand-computed literal expectations.
module tb_cdb_broadcast;
  import cdb_broadcast_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic squash;
  cdb_broadcast_if bus();

  cdb_broadcast dut (
    .clock  (clock),
    .reset  (reset),
    .squash (squash),
    .bus    (bus.slave)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  // Reference model: pending results per FU and the rotation start.
  bit              m_valid [NFU];
  FU_RESULT_PACKET m_slot  [NFU];
  int              m_ptr = 0;
  bit              exp_v   [CDBW];
  FU_RESULT_PACKET exp_pkt [CDBW];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic FU_RESULT_PACKET mk(input int tag, input int val, input int rob);
    FU_RESULT_PACKET p;
    p.dest_pr = PRW'(tag);
    p.value   = XLEN'(val);
    p.rob_idx = ROBW'(rob);
    return p;
  endfunction

  // Oldest-first scan from the model pointer, at most CDBW picks.
  function automatic void pick(output int idx[CDBW], output int n);
    n = 0;
    for (int i = 0; i < CDBW; i++) idx[i] = -1;
    for (int j = 0; j < NFU; j++) begin
      int s;
      s = (m_ptr + j) % NFU;
      if (m_valid[s] && n < CDBW) begin
        idx[n] = s;
        n++;
      end
    end
  endfunction

  initial begin
    for (int k = 0; k < NFU; k++) begin m_valid[k] = 1'b0; m_slot[k] = '0; end
    for (int l = 0; l < CDBW; l++) begin exp_v[l] = 1'b0; exp_pkt[l] = '0; end
    forever begin
      int idx[CDBW];
      int n;
      @(posedge clock or posedge reset);
      if (reset) begin
        for (int k = 0; k < NFU; k++) m_valid[k] = 1'b0;
        for (int l = 0; l < CDBW; l++) begin exp_v[l] = 1'b0; exp_pkt[l] = '0; end
        m_ptr = 0;
      end else if (squash) begin
        for (int k = 0; k < NFU; k++) m_valid[k] = 1'b0;
        for (int l = 0; l < CDBW; l++) begin exp_v[l] = 1'b0; exp_pkt[l] = '0; end
      end else begin
        pick(idx, n);
        for (int l = 0; l < CDBW; l++) begin exp_v[l] = 1'b0; exp_pkt[l] = '0; end
        for (int i = 0; i < n; i++) begin
          exp_v[CDBW-1-i]   = 1'b1;
          exp_pkt[CDBW-1-i] = m_slot[idx[i]];
          m_valid[idx[i]]   = 1'b0;
        end
        if (n > 0) m_ptr = (idx[n-1] + 1) % NFU;
        for (int k = 0; k < NFU; k++) begin
          if (bus.fu_done[k]) begin
            m_valid[k] = 1'b1;
            m_slot[k]  = bus.fu_result[k];
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      int idx[CDBW];
      int n;
      logic [NFU-1:0] er;
      logic [CDBW-1:0] ev;
      logic [NFU-1:0] rv;
      @(negedge clock);
      if (cmp_en) begin
        pick(idx, n);
        for (int k = 0; k < NFU; k++) begin
          bit g;
          g = 1'b0;
          for (int i = 0; i < n; i++) if (idx[i] == k) g = 1'b1;
          er[k] = !bus.fu_busy[k] && (!m_valid[k] || g);
        end
        for (int l = 0; l < CDBW; l++) ev[l] = exp_v[l];
        rv = bus.fu_ready;
        check("model_fu_ready", 64'(rv), 64'(er));
        check("model_cdb_valid", 64'(bus.cdb_valid), 64'(ev));
        for (int l = 0; l < CDBW; l++)
          check("model_cdb_pckt", 64'(bus.cdb_pckt[l]), 64'(exp_pkt[l]));
        check("model_cdb_t", 64'({bus.cdb_t.t2, bus.cdb_t.t1, bus.cdb_t.t0}),
              64'({exp_pkt[2].dest_pr, exp_pkt[1].dest_pr, exp_pkt[0].dest_pr}));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [NFU-1:0] ready_vec();
    logic [NFU-1:0] v;
    v = bus.fu_ready;
    return v;
  endfunction

  function automatic logic [3*PRW-1:0] tags();
    return {bus.cdb_t.t2, bus.cdb_t.t1, bus.cdb_t.t0};
  endfunction

  initial begin
    int seen_at;
    reset = 1'b1;
    squash = 1'b0;
    bus.fu_done = '0;
    bus.fu_result = '0;
    bus.fu_busy = '0;
    #12;
    reset = 1'b0;
    check("reset_valid", 64'(bus.cdb_valid), 64'd0);
    check("reset_ready", 64'(ready_vec()), 64'hFF);
    check("reset_tags", 64'(tags()), 64'd0);
    cmp_en = 1'b1;
    tick();

    // Oversubscription: all eight finish together, tags 1..8.
    bus.fu_done = 8'hFF;
    for (int k = 0; k < NFU; k++) bus.fu_result[k] = mk(k + 1, 32'hA0 + k, k);
    tick();
    bus.fu_done = 8'h00;
    check("over_ready0", 64'(ready_vec()), 64'h07);
    tick();
    check("over_tags0", 64'(tags()), 64'({6'd1, 6'd2, 6'd3}));
    check("over_valid0", 64'(bus.cdb_valid), 64'(3'b111));
    check("over_ready1", 64'(ready_vec()), 64'h3F);
    tick();
    check("over_tags1", 64'(tags()), 64'({6'd4, 6'd5, 6'd6}));
    check("over_ready2", 64'(ready_vec()), 64'hFF);
    tick();
    check("over_tags2", 64'(tags()), 64'({6'd7, 6'd8, 6'd0}));
    check("over_valid2", 64'(bus.cdb_valid), 64'(3'b110));
    tick();
    check("over_idle", 64'(bus.cdb_valid), 64'd0);

    // Single result on ALU_1; pointer is back at 0.
    bus.fu_done = 8'h01;
    bus.fu_result[0] = mk(5, 32'h1234, 3);
    tick();
    bus.fu_done = 8'h00;
    check("single_ready", 64'(bus.fu_ready.alu_1), 64'd1);
    bus.fu_busy = 8'h10;
    #1;
    check("busy_ready", 64'(ready_vec()), 64'hEF);
    tick();
    bus.fu_busy = 8'h00;
    check("single_valid", 64'(bus.cdb_valid), 64'(3'b100));
    check("single_tags", 64'(tags()), 64'({6'd5, 6'd0, 6'd0}));
    check("single_value", 64'(bus.cdb_pckt[2].value), 64'h1234);
    tick();
    check("single_idle", 64'(bus.cdb_valid), 64'd0);

    // Back-to-back on MULT_1, tags 7 then 9.
    bus.fu_done = 8'h08;
    bus.fu_result[3] = mk(7, 32'h77, 4);
    tick();
    bus.fu_result[3] = mk(9, 32'h99, 5);
    check("b2b_ready", 64'(bus.fu_ready.mult_1), 64'd1);
    tick();
    bus.fu_done = 8'h00;
    check("b2b_first", 64'(tags()), 64'({6'd7, 6'd0, 6'd0}));
    tick();
    check("b2b_second", 64'(tags()), 64'({6'd9, 6'd0, 6'd0}));
    check("b2b_valid", 64'(bus.cdb_valid), 64'(3'b100));
    tick();

    // Starvation: ALUs refill whenever offered, plus one LS_1 result.
    seen_at = -1;
    for (int it = 0; it < 6; it++) begin
      logic [NFU-1:0] d;
      d = '0;
      d[2:0] = ready_vec() & 8'h07;
      if (it == 0) begin
        d[FU_LS_1] = 1'b1;
        bus.fu_result[FU_LS_1] = mk(20, 32'h2020, 6);
      end
      for (int k = 0; k < 3; k++) bus.fu_result[k] = mk(10 + k, 32'h100 + it, k);
      bus.fu_done = d;
      tick();
      if (seen_at < 0 && bus.cdb_valid[2] && bus.cdb_t.t2 == 6'd20) seen_at = it;
      if (seen_at < 0 && bus.cdb_valid[1] && bus.cdb_t.t1 == 6'd20) seen_at = it;
      if (seen_at < 0 && bus.cdb_valid[0] && bus.cdb_t.t0 == 6'd20) seen_at = it;
    end
    bus.fu_done = 8'h00;
    check("starve_in_time", 64'(seen_at >= 1 && seen_at <= 3), 64'd1);
    repeat (4) tick();

    // Squash with four pending slots and a same-edge BRANCH result.
    bus.fu_done = 8'h2B;
    for (int k = 0; k < NFU; k++) bus.fu_result[k] = mk(40 + k, 32'h400 + k, k);
    tick();
    bus.fu_done = 8'h80;
    bus.fu_result[7] = mk(30, 32'h3030, 7);
    squash = 1'b1;
    tick();
    squash = 1'b0;
    bus.fu_done = 8'h00;
    check("squash_valid", 64'(bus.cdb_valid), 64'd0);
    check("squash_ready", 64'(ready_vec()), 64'hFF);
    check("squash_tags", 64'(tags()), 64'd0);
    tick();
    check("squash_dropped", 64'(bus.cdb_valid), 64'd0);

    // Reset between edges while all three lanes are live.
    bus.fu_done = 8'hFF;
    tick();
    bus.fu_done = 8'h00;
    tick();
    check("pre_reset_valid", 64'(bus.cdb_valid), 64'(3'b111));
    #2;
    reset = 1'b1;
    #1;
    check("midreset_valid", 64'(bus.cdb_valid), 64'd0);
    check("midreset_ready", 64'(ready_vec()), 64'hFF);
    check("midreset_tags", 64'(tags()), 64'd0);
    reset = 1'b0;
    tick();
    check("post_reset_idle", 64'(bus.cdb_valid), 64'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/cdb_broadcast.md
Name: cdb_broadcast

Overview:
- Complete-stage arbiter. Collects finished results from the 8 functional units (ALU_1..3, MULT_1..2, LS_1..2, BRANCH) into one holding slot per FU.
- Picks up to 3 slots per cycle and drives them onto the 3-wide CDB. The broadcast tags go to the RS wakeup logic (cdb_t); the values go to the physical register file and the ROB.
- Back-pressures the FUs through the FU_STATE_PACKET consumed by RS issue select. An FU is only offered to issue when its result slot will be free.

Parameters:
- PRW, 6, physical register tag width (matches CDB_T_PACKET.t*)
- NFU, 8, number of FU result ports; bit order ALU_1, ALU_2, ALU_3, MULT_1, MULT_2, LS_1, LS_2, BRANCH (bit 0..7)
- CDBW, 3, CDB lanes

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- squash  in  1  pipeline flush (mispredict), synchronous
- fu_done  in  NFU  FU k presents a result this cycle
- fu_result  in  NFU x FU_RESULT_PACKET  {dest_pr[PRW], value[XLEN], rob_idx}
- fu_busy  in  NFU  FU k internally occupied (e.g. multi-cycle mult in flight)
- cdb_t  out  CDB_T_PACKET  broadcast tags t0,t1,t2
- cdb_pckt  out  CDBW x FU_RESULT_PACKET  full results per lane, lane 2 = t2
- cdb_valid  out  CDBW  lane carries a real result
- fu_ready  out  FU_STATE_PACKET  per-FU ready to the RS

Behaviour:
- Reset (async, immediate):
  - all slots invalid
  - cdb_t.t0/t1/t2 = 0, cdb_pckt = 0, cdb_valid = 0
  - rotate pointer = 0
  - fu_ready = all 1 (fu_busy is 0 after reset)
- Slot capture: at each posedge, if fu_done[k], slot k <= fu_result[k] and becomes valid.
- Selection (combinational on the slot state):
  - rotating priority starting at the pointer
  - first grant goes to lane 2, second to lane 1, third to lane 0
  - fewer than 3 valid slots: the unused lanes have cdb_valid = 0 and tag 0
  - tag 0 is the hardwired zero register; broadcasting it is harmless to the RS
- Broadcast: at the posedge, granted slots are copied into the cdb registers and the slot is cleared. Latency from fu_done to cdb_valid is 2 edges minimum: capture edge plus broadcast edge.
- Pointer: after any grant, the pointer moves to (index of the last granted slot + 1) mod NFU. It is unchanged when nothing is granted. This prevents starvation; any valid slot broadcasts within ceil(NFU/CDBW) = 3 cycles.
- Same-edge capture and drain: if slot k is granted and fu_done[k] is high on the same edge, the new result is captured (slot stays valid). There is no bubble.
- fu_ready[k] = (~slot_valid[k] | grant[k]) & ~fu_busy[k].
  - Combinational from state and fu_busy only; no path from fu_done, so no loop with RS issue.
  - Field mapping: alu_1..3, mult_1..2, storeload_1..2, branch.
- fu_done[k] while the slot is valid and not granted is a protocol violation. Flag it with an assertion; the new data overwrites the slot.
- squash at a posedge:
  - all slots cleared, cdb_valid = 0, tags 0
  - the pointer is held
  - fu_done on the same edge is dropped (squash wins)
- Reset asserted mid-broadcast clears outputs immediately, without waiting for a clock edge.
- CDB outputs are fully registered; no combinational path from inputs to cdb_*.

Decomposition:
- Shared package (sys_defs): FU_RESULT_PACKET typedef; NFU/CDBW constants; the FU bit-index enum aligned with FU_SELECT; reuse the existing CDB_T_PACKET and FU_STATE_PACKET.
- Sub-module rr_sel8: an 8-input rotating-priority selector that grants up to 3 requests and outputs 3 one-hot grants plus the next pointer. It is verified standalone.

Test Plan:
- Reset mid-operation: assert reset between edges while cdb_valid=3'b111 -> outputs go to 0 and fu_ready to 8'hFF immediately, before the next clock edge.
- Single result: fu_done[0] with dest_pr=5 -> two edges later cdb_t.t2=5, cdb_valid=3'b100, t1=t0=0; fu_ready.alu_1 low for exactly 0 cycles (the slot is granted the cycle after capture).
- Oversubscription: all 8 fu_done for one cycle, dest_pr=1..8 -> broadcasts {1,2,3}, {4,5,6}, {7,8,-} on consecutive cycles; the pointer lands at 0; each fu_ready stays low until its grant cycle.
- Starvation: hold fu_done[0..2] high every cycle (tags 10,11,12) plus one LS_1 result (tag 20) -> tag 20 broadcasts within 3 cycles of capture.
- Back-to-back: fu_done[3] on consecutive cycles (tags 7, 9) with no contention -> tag 7 then tag 9 on t2 in consecutive cycles; no overwrite assertion fires.
- Squash: 4 slots valid, assert squash together with fu_done[7] -> next cycle cdb_valid=0, all slots empty, BRANCH result dropped, fu_ready=8'hFF (with fu_busy=0).
